// File: rtl/vga_board_painter_pkg.sv
// Shared types, colours and board geometry helpers for the tic-tac-toe painter.
package vga_board_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    WIN_P1 = 2'd1,
    WIN_P2 = 2'd2,
    DRAW   = 2'd3
  } game_state_t;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  localparam logic [23:0] RGB_BLACK     = 24'h000000;
  localparam logic [23:0] RGB_WIN_P1_BG = 24'h400000;
  localparam logic [23:0] RGB_WIN_P2_BG = 24'h000040;
  localparam logic [23:0] RGB_DRAW_BG   = 24'h404040;
  localparam logic [23:0] RGB_CURSOR    = 24'hFFFF00;
  localparam logic [23:0] RGB_GRID      = 24'hFFFFFF;
  localparam logic [23:0] RGB_P1        = 24'hFF0000;
  localparam logic [23:0] RGB_P2        = 24'h0000FF;
  localparam logic [23:0] RGB_EMPTY     = 24'h202020;

  // Winning line table: three 4-bit cell indices packed per line.
  function automatic logic [11:0] win_line(input int idx);
    case (idx)
      0:       win_line = {4'd0, 4'd1, 4'd2};
      1:       win_line = {4'd3, 4'd4, 4'd5};
      2:       win_line = {4'd6, 4'd7, 4'd8};
      3:       win_line = {4'd0, 4'd3, 4'd6};
      4:       win_line = {4'd1, 4'd4, 4'd7};
      5:       win_line = {4'd2, 4'd5, 4'd8};
      6:       win_line = {4'd0, 4'd4, 4'd8};
      default: win_line = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  function automatic logic [1:0] cell_col(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: cell_col = 2'd0;
      4'd1, 4'd4, 4'd7: cell_col = 2'd1;
      default:          cell_col = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] cell_row(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: cell_row = 2'd0;
      4'd3, 4'd4, 4'd5: cell_row = 2'd1;
      default:          cell_row = 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] cell_index(input logic [1:0] col, input logic [1:0] row);
    cell_index = ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

endpackage

// File: rtl/vga_board_painter_if.sv
// Video stream between the VGA timing controller (master) and the painter (slave).
interface vga_board_painter_if;
  logic [9:0] posx;
  logic [9:0] posy;
  logic       h_sync;
  logic       v_sync;
  logic       blank_n;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       h_sync_o;
  logic       v_sync_o;
  logic       blank_n_o;

  modport master (
    output posx, posy, h_sync, v_sync, blank_n,
    input  red, green, blue, h_sync_o, v_sync_o, blank_n_o
  );

  modport slave (
    input  posx, posy, h_sync, v_sync, blank_n,
    output red, green, blue, h_sync_o, v_sync_o, blank_n_o
  );
endinterface

// File: rtl/vga_board_painter_win_check.sv
// Combinational win / full detection over a 3x3 board.
module board_win_check
  import vga_board_pkg::*;
(
  input  cell_t cells [NUM_CELLS],
  output logic  win_p1,
  output logic  win_p2,
  output logic  full
);

  // Scan the eight lines for a uniform owner, and every cell for occupancy.
  always_comb begin
    logic [11:0] trip;
    trip   = '0;
    win_p1 = 1'b0;
    win_p2 = 1'b0;
    full   = 1'b1;
    for (int l = 0; l < NUM_LINES; l++) begin
      trip = win_line(l);
      if (cells[trip[11:8]] == P1 && cells[trip[7:4]] == P1 && cells[trip[3:0]] == P1)
        win_p1 = 1'b1;
      if (cells[trip[11:8]] == P2 && cells[trip[7:4]] == P2 && cells[trip[3:0]] == P2)
        win_p2 = 1'b1;
    end
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cells[i] == EMPTY) full = 1'b0;
    end
  end

endmodule

// File: rtl/vga_board_painter.sv
// Tic-tac-toe pixel painter: game FSM driven by two buttons plus a 2-clk render
// pipeline. Optional macro CURSOR_BLINK_EN blinks the cursor border on a
// 5-bit frame counter clocked by v_sync falling edges.
module vga_board_painter
  import vga_board_pkg::*;
#(
  parameter int BOARD_X0 = 80,
  parameter int BOARD_Y0 = 0,
  parameter int CELL     = 160,
  parameter int LINE_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  vga_board_painter_if.slave        vid,
  input  logic                      btn_next,
  input  logic                      btn_mark,
  output logic [1:0]                game_state,
  output logic                      turn
);

  // 11-bit geometry so board extents never wrap against 10-bit coordinates.
  localparam logic [10:0] X_B0   = 11'(BOARD_X0);
  localparam logic [10:0] X_B1   = 11'(BOARD_X0 + CELL);
  localparam logic [10:0] X_B2   = 11'(BOARD_X0 + 2 * CELL);
  localparam logic [10:0] X_END  = 11'(BOARD_X0 + 3 * CELL);
  localparam logic [10:0] Y_B0   = 11'(BOARD_Y0);
  localparam logic [10:0] Y_B1   = 11'(BOARD_Y0 + CELL);
  localparam logic [10:0] Y_B2   = 11'(BOARD_Y0 + 2 * CELL);
  localparam logic [10:0] Y_END  = 11'(BOARD_Y0 + 3 * CELL);
  localparam logic [10:0] LW     = 11'(LINE_W);
  localparam logic [10:0] LW_FAR = 11'(CELL - LINE_W);

  // ---------------- game state ----------------
  logic        btn_next_q, btn_mark_q;
  logic        next_edge, mark_edge;
  game_state_t state_q, state_d;
  cell_t       cells_q [NUM_CELLS];
  cell_t       cells_d [NUM_CELLS];
  logic [3:0]  cursor_q, cursor_d;
  logic        turn_q, turn_d;
  logic        win_p1, win_p2, full;
  logic        cursor_vis;

  assign next_edge = btn_next & ~btn_next_q;
  assign mark_edge = btn_mark & ~btn_mark_q;

  // Button history; reset high so a button held through reset gives no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_next_q <= 1'b1;
      btn_mark_q <= 1'b1;
    end else begin
      btn_next_q <= btn_next;
      btn_mark_q <= btn_mark;
    end
  end

  // Game registers: state, board, cursor and whose turn it is.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PLAY;
      cursor_q <= 4'd0;
      turn_q   <= 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) cells_q[i] <= EMPTY;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      turn_q   <= turn_d;
      for (int i = 0; i < NUM_CELLS; i++) cells_q[i] <= cells_d[i];
    end
  end

  // Board update: mark uses the pre-move cursor, then next advances it.
  always_comb begin
    cursor_d = cursor_q;
    turn_d   = turn_q;
    for (int i = 0; i < NUM_CELLS; i++) cells_d[i] = cells_q[i];
    if (state_q == PLAY) begin
      if (mark_edge && cells_q[cursor_q] == EMPTY) begin
        cells_d[cursor_q] = turn_q ? P2 : P1;
        turn_d            = ~turn_q;
      end
      if (next_edge) cursor_d = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
    end else if (mark_edge) begin
      for (int i = 0; i < NUM_CELLS; i++) cells_d[i] = EMPTY;
      cursor_d = 4'd0;
      turn_d   = 1'b0;
    end
  end

  // Judge the board as it will look after this cycle's write.
  board_win_check u_win (
    .cells  (cells_d),
    .win_p1 (win_p1),
    .win_p2 (win_p2),
    .full   (full)
  );

  // Next-state: win beats draw; finished games wait for a mark to restart.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PLAY: begin
        if (win_p1)      state_d = WIN_P1;
        else if (win_p2) state_d = WIN_P2;
        else if (full)   state_d = DRAW;
      end
      default: begin
        if (mark_edge) state_d = PLAY;
      end
    endcase
  end

  assign game_state = state_q;
  assign turn       = turn_q;

`ifdef CURSOR_BLINK_EN
  logic [4:0] frame_cnt_q;
  logic       v_sync_hist_q;

  // Count frames on v_sync falling edges to pace the cursor blink.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q   <= 5'd0;
      v_sync_hist_q <= 1'b1;
    end else begin
      v_sync_hist_q <= vid.v_sync;
      if (v_sync_hist_q && !vid.v_sync) frame_cnt_q <= frame_cnt_q + 5'd1;
    end
  end

  assign cursor_vis = ~frame_cnt_q[4];
`else
  assign cursor_vis = 1'b1;
`endif

  // ---------------- stage 1: geometry ----------------
  logic [10:0] x_s0, y_s0, xoff_s0, yoff_s0;
  logic [1:0]  col_s0, row_s0;
  logic        in_board_s0, on_grid_s0, on_cursor_s0;
  logic [3:0]  cell_idx_s0;

  // Locate the pixel: cell by comparisons against boundaries, offset within cell.
  always_comb begin
    x_s0        = {1'b0, vid.posx};
    y_s0        = {1'b0, vid.posy};
    in_board_s0 = (x_s0 >= X_B0) && (x_s0 < X_END) && (y_s0 >= Y_B0) && (y_s0 < Y_END);
    if (x_s0 < X_B1) begin
      col_s0  = 2'd0;
      xoff_s0 = x_s0 - X_B0;
    end else if (x_s0 < X_B2) begin
      col_s0  = 2'd1;
      xoff_s0 = x_s0 - X_B1;
    end else begin
      col_s0  = 2'd2;
      xoff_s0 = x_s0 - X_B2;
    end
    if (y_s0 < Y_B1) begin
      row_s0  = 2'd0;
      yoff_s0 = y_s0 - Y_B0;
    end else if (y_s0 < Y_B2) begin
      row_s0  = 2'd1;
      yoff_s0 = y_s0 - Y_B1;
    end else begin
      row_s0  = 2'd2;
      yoff_s0 = y_s0 - Y_B2;
    end
    // Grid lines only at internal boundaries; the outer frame stays undrawn.
    on_grid_s0   = ((col_s0 != 2'd0) && (xoff_s0 < LW)) ||
                   ((row_s0 != 2'd0) && (yoff_s0 < LW));
    on_cursor_s0 = (col_s0 == cell_col(cursor_q)) && (row_s0 == cell_row(cursor_q)) &&
                   ((xoff_s0 < LW) || (xoff_s0 >= LW_FAR) ||
                    (yoff_s0 < LW) || (yoff_s0 >= LW_FAR));
    cell_idx_s0  = cell_index(col_s0, row_s0);
  end

  logic       h_sync_p1_q, v_sync_p1_q, blank_n_p1_q;
  logic       in_board_p1_q, on_grid_p1_q, on_cursor_p1_q;
  logic [3:0] cell_idx_p1_q;

  // Stage 1 register: syncs plus classified pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_sync_p1_q    <= 1'b1;
      v_sync_p1_q    <= 1'b1;
      blank_n_p1_q   <= 1'b0;
      in_board_p1_q  <= 1'b0;
      on_grid_p1_q   <= 1'b0;
      on_cursor_p1_q <= 1'b0;
      cell_idx_p1_q  <= 4'd0;
    end else begin
      h_sync_p1_q    <= vid.h_sync;
      v_sync_p1_q    <= vid.v_sync;
      blank_n_p1_q   <= vid.blank_n;
      in_board_p1_q  <= in_board_s0;
      on_grid_p1_q   <= on_grid_s0;
      on_cursor_p1_q <= on_cursor_s0;
      cell_idx_p1_q  <= cell_idx_s0;
    end
  end

  // ---------------- stage 2: colour ----------------
  logic [23:0] rgb_p1;

  // Colour priority: blank, background, cursor border, grid, cell contents.
  always_comb begin
    rgb_p1 = RGB_BLACK;
    if (!blank_n_p1_q) begin
      rgb_p1 = RGB_BLACK;
    end else if (!in_board_p1_q) begin
      case (state_q)
        PLAY:    rgb_p1 = RGB_BLACK;
        WIN_P1:  rgb_p1 = RGB_WIN_P1_BG;
        WIN_P2:  rgb_p1 = RGB_WIN_P2_BG;
        default: rgb_p1 = RGB_DRAW_BG;
      endcase
    end else if (on_cursor_p1_q && (state_q == PLAY) && cursor_vis) begin
      rgb_p1 = RGB_CURSOR;
    end else if (on_grid_p1_q) begin
      rgb_p1 = RGB_GRID;
    end else begin
      case (cells_q[cell_idx_p1_q])
        P1:      rgb_p1 = RGB_P1;
        P2:      rgb_p1 = RGB_P2;
        default: rgb_p1 = RGB_EMPTY;
      endcase
    end
  end

  logic [23:0] rgb_p2_q;
  logic        h_sync_p2_q, v_sync_p2_q, blank_n_p2_q;

  // Stage 2 register: colour and syncs leave aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p2_q     <= RGB_BLACK;
      h_sync_p2_q  <= 1'b1;
      v_sync_p2_q  <= 1'b1;
      blank_n_p2_q <= 1'b0;
    end else begin
      rgb_p2_q     <= rgb_p1;
      h_sync_p2_q  <= h_sync_p1_q;
      v_sync_p2_q  <= v_sync_p1_q;
      blank_n_p2_q <= blank_n_p1_q;
    end
  end

  assign vid.red       = rgb_p2_q[23:16];
  assign vid.green     = rgb_p2_q[15:8];
  assign vid.blue      = rgb_p2_q[7:0];
  assign vid.h_sync_o  = h_sync_p2_q;
  assign vid.v_sync_o  = v_sync_p2_q;
  assign vid.blank_n_o = blank_n_p2_q;

endmodule
